// File: rtl/apb_matmul_arbiter.sv
// Round-robin APB master that shares the matmul engine's slave port.
// A start write holds the port until the engine reports done or times out.
module apb_matmul_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int BUS_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int STRB_WIDTH     = BUS_WIDTH/8,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int IW            = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]  req_wdata_i,
  input  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [BUS_WIDTH-1:0]          rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic                          psel_o,
  output logic                          penable_o,
  output logic                          pwrite_o,
  output logic [ADDR_WIDTH-1:0]         paddr_o,
  output logic [BUS_WIDTH-1:0]          pwdata_o,
  output logic [STRB_WIDTH-1:0]         pstrb_o,
  input  logic [BUS_WIDTH-1:0]          prdata_i,
  input  logic                          pready_i,
  input  logic                          pslverr_i,
  input  logic                          done_i,
  output logic                          busy_o,
  output logic [IW-1:0]                 owner_o,
  output logic                          timeout_o
);

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, WAIT_DONE
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]         last_grant;
  logic [IW-1:0]         cand;
  logic [IW-1:0]         gnt_idx;
  logic                  gnt_valid;
  logic                  gnt_en;
  logic                  xfer_done;
  logic                  start_hit;
  logic                  tmo_hit;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [BUS_WIDTH-1:0]  lat_wdata;
  logic [STRB_WIDTH-1:0] lat_strb;
  logic [31:0]           cnt;

  // Walk from farthest to nearest so last+1 wins ties.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = last_grant;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid_i[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign gnt_en    = rst && (state == IDLE) && gnt_valid;
  assign xfer_done = (state == ACCESS) && pready_i;
  assign start_hit = lat_write && (lat_addr == START_ADDR)
                  && lat_wdata[0] && !pslverr_i;
  assign tmo_hit   = (state == WAIT_DONE) && !done_i
                  && (cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    req_ready_o = '0;
    unique case (state)
      IDLE: begin
        if (gnt_en) begin
          req_ready_o[gnt_idx] = 1'b1;
          state_nxt            = SETUP;
        end
      end
      SETUP: begin
        psel_o    = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (pready_i) state_nxt = start_hit ? WAIT_DONE : IDLE;
      end
      WAIT_DONE: begin
        if (done_i || tmo_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o   = (state != IDLE);
  assign pwrite_o = lat_write;
  assign paddr_o  = lat_addr;
  assign pwdata_o = lat_wdata;
  assign pstrb_o  = lat_strb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant  <= IW'(NUM_REQ - 1);
      owner_o     <= '0;
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_strb    <= '0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      cnt         <= '0;
      timeout_o   <= 1'b0;
    end else begin
      rsp_valid_o <= '0;
      if (gnt_en) begin
        last_grant <= gnt_idx;
        owner_o    <= gnt_idx;
        lat_write  <= req_write_i[gnt_idx];
        lat_addr   <= req_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        lat_wdata  <= req_wdata_i[gnt_idx*BUS_WIDTH +: BUS_WIDTH];
        lat_strb   <= req_strb_i[gnt_idx*STRB_WIDTH +: STRB_WIDTH];
      end
      if (xfer_done) begin
        rsp_valid_o[owner_o] <= 1'b1;
        rsp_rdata_o          <= lat_write ? '0 : prdata_i;
        rsp_err_o            <= pslverr_i;
      end
      if (state == ACCESS)         cnt <= '0;
      else if (state == WAIT_DONE) cnt <= cnt + 32'd1;
      if (tmo_hit) timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_matmul_arbiter.sv
// Directed bench for apb_matmul_arbiter: grants, APB phasing,
// start-lock with done and timeout, read errors and mid-transfer reset.
module tb_apb_matmul_arbiter;

  localparam int NR = 2;
  localparam int BW = 32;
  localparam int AW = 32;
  localparam int SW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NR-1:0]  req_valid = '0;
  logic [NR-1:0]  req_write = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*BW-1:0] req_wdata = '0;
  logic [NR*SW-1:0] req_strb = '0;
  logic [NR-1:0]  req_ready;
  logic [NR-1:0]  rsp_valid;
  logic [BW-1:0]  rsp_rdata;
  logic           rsp_err;
  logic           psel, penable, pwrite;
  logic [AW-1:0]  paddr;
  logic [BW-1:0]  pwdata;
  logic [SW-1:0]  pstrb;
  logic [BW-1:0]  prdata = '0;
  logic           pready = 1'b0;
  logic           pslverr = 1'b0;
  logic           done = 1'b0;
  logic           busy;
  logic           owner;
  logic           timeout;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  apb_matmul_arbiter #(
    .NUM_REQ(NR), .BUS_WIDTH(BW), .ADDR_WIDTH(AW),
    .STRB_WIDTH(SW), .START_ADDR(32'h0), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_strb_i(req_strb), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .psel_o(psel), .penable_o(penable),
    .pwrite_o(pwrite), .paddr_o(paddr), .pwdata_o(pwdata),
    .pstrb_o(pstrb), .prdata_i(prdata), .pready_i(pready),
    .pslverr_i(pslverr), .done_i(done), .busy_o(busy),
    .owner_o(owner), .timeout_o(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    req_write[r]          = w;
    req_addr[r*AW +: AW]  = a;
    req_wdata[r*BW +: BW] = d;
    req_strb[r*SW +: SW]  = s;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    logic [1:0] exp;
    int n;
    bit stall_ok;

    // reset: everything quiet even with requests pending
    req_valid = 2'b11;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_psel", psel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_owner", owner, 0);
    chk("rst_tmo", timeout, 0);
    req_valid = '0;
    tick();
    tick();
    rst = 1'b1;

    // T1: single write
    set_req(0, 1, 32'h4, 32'h11, 4'hF);
    pready = 1'b1;
    req_valid = 2'b01;
    #1;
    chk("t1_ready", req_ready, 2'b01);
    chk("t1_busy_idle", busy, 0);
    tick();
    req_valid = '0;
    #1;
    chk("t1_setup_psel", psel, 1);
    chk("t1_setup_pen", penable, 0);
    chk("t1_paddr", paddr, 32'h4);
    chk("t1_pwdata", pwdata, 32'h11);
    chk("t1_pstrb", pstrb, 4'hF);
    chk("t1_pwrite", pwrite, 1);
    chk("t1_busy_setup", busy, 1);
    tick();
    chk("t1_acc_psel", psel, 1);
    chk("t1_acc_pen", penable, 1);
    chk("t1_busy_acc", busy, 1);
    tick();
    chk("t1_rsp", rsp_valid, 2'b01);
    chk("t1_err", rsp_err, 0);
    chk("t1_rdata", rsp_rdata, 0);
    chk("t1_busy_end", busy, 0);

    // T2: alternating grants
    do_reset();
    set_req(0, 1, 32'h4, 32'h11, 4'hF);
    set_req(1, 1, 32'h4, 32'h22, 4'hF);
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 1) ? 2'b10 : 2'b01;
      chk("t2_ready", req_ready, exp);
      tick();
      chk("t2_pwdata", pwdata, (i % 2 == 1) ? 32'h22 : 32'h11);
      tick();
      tick();
      chk("t2_rsp", rsp_valid, exp);
    end
    req_valid = '0;

    // T3: start write locks the port until done
    set_req(1, 1, 32'h0, 32'h1, 4'hF);
    req_valid = 2'b10;
    #1;
    chk("t3_ready1", req_ready, 2'b10);
    tick();
    set_req(0, 1, 32'h4, 32'h33, 4'hF);
    req_valid = 2'b01;
    #1;
    chk("t3_paddr", paddr, 32'h0);
    tick();
    done = 1'b1;
    #1;
    chk("t3_acc_pen", penable, 1);
    tick();
    done = 1'b0;
    #1;
    chk("t3_wait_busy", busy, 1);
    chk("t3_wait_psel", psel, 0);
    chk("t3_rsp", rsp_valid, 2'b10);
    chk("t3_stall_ready", req_ready, 0);
    stall_ok = 1'b1;
    for (int j = 0; j < 11; j++) begin
      tick();
      if (psel || penable || req_ready != 0 || !busy) stall_ok = 1'b0;
    end
    chk("t3_stall", 32'(stall_ok), 1);
    done = 1'b1;
    #1;
    tick();
    done = 1'b0;
    #1;
    chk("t3_ready0", req_ready, 2'b01);
    chk("t3_tmo", timeout, 0);
    tick();
    req_valid = '0;
    #1;
    chk("t3_paddr0", paddr, 32'h4);
    chk("t3_pwdata0", pwdata, 32'h33);
    chk("t3_owner", owner, 0);
    tick();
    tick();
    chk("t3_rsp0", rsp_valid, 2'b01);

    // T4: read with wait states and slave error
    set_req(0, 0, 32'h8, 32'h0, 4'hF);
    pready = 1'b0;
    req_valid = 2'b01;
    #1;
    chk("t4_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    #1;
    chk("t4_pwrite", pwrite, 0);
    chk("t4_paddr", paddr, 32'h8);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (psel && penable) n++;
      if (k == 3) begin
        pready  = 1'b1;
        prdata  = 32'hDEAD;
        pslverr = 1'b1;
      end
    end
    chk("t4_acc_cycles", n, 4);
    tick();
    chk("t4_rsp", rsp_valid, 2'b01);
    chk("t4_rdata", rsp_rdata, 32'hDEAD);
    chk("t4_err", rsp_err, 1);
    chk("t4_busy", busy, 0);

    // T4b: start write rejected by slave error does not lock
    set_req(0, 1, 32'h0, 32'h1, 4'hF);
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("t4b_busy", busy, 0);
    chk("t4b_err", rsp_err, 1);
    chk("t4b_rdata", rsp_rdata, 0);
    pslverr = 1'b0;
    prdata  = '0;

    // T5: timeout without done
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("t5_tmo_pre", timeout, 0);
    chk("t5_wait", busy, 1);
    n = 1;
    while (busy && n < 40) begin
      tick();
      if (busy) n++;
    end
    chk("t5_wait_cycles", n, 16);
    chk("t5_tmo", timeout, 1);
    set_req(1, 1, 32'h4, 32'h44, 4'h3);
    req_valid = 2'b10;
    #1;
    tick();
    req_valid = '0;
    #1;
    chk("t5_pstrb", pstrb, 4'h3);
    tick();
    tick();
    chk("t5_rsp", rsp_valid, 2'b10);
    chk("t5_owner", owner, 1);
    chk("t5_sticky", timeout, 1);

    // T6: reset during ACCESS
    set_req(0, 1, 32'h4, 32'h55, 4'hF);
    pready = 1'b0;
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = '0;
    tick();
    chk("t6_acc", penable, 1);
    rst = 1'b0;
    #1;
    chk("t6_psel", psel, 0);
    chk("t6_pen", penable, 0);
    chk("t6_busy", busy, 0);
    chk("t6_tmo_clr", timeout, 0);
    pready = 1'b1;
    tick();
    chk("t6_no_rsp", rsp_valid, 0);
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("t6_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("t6_rsp", rsp_valid, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
